// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, encodings and helpers for the ALU sequencer
package alu_seq_pkg;

  localparam int OP_W    = 3;
  localparam int REG_W   = 2;
  localparam int DATA_W  = 4;
  localparam int INSTR_W = 11;
  localparam int NREGS   = 4;
  localparam int CNT_W   = 8;

  localparam int OP_LSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS_LSB  = 4;
  localparam int IMM_LSB = 0;
  localparam int RT_LSB  = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_LSH = 3'd2,
    OP_RSH = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_LDI = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int STB_ADD = 0;
  localparam int STB_SUB = 1;
  localparam int STB_LSH = 2;
  localparam int STB_RSH = 3;
  localparam int STB_AND = 4;
  localparam int STB_OR  = 5;
  localparam int STB_XOR = 6;
  localparam int NSTB    = 7;

  function automatic logic is_shift(input op_t op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

  function automatic logic [NSTB-1:0] strobe_of(input op_t op);
    logic [NSTB-1:0] s;
    s = '0;
    case (op)
      OP_ADD:  s[STB_ADD] = 1'b1;
      OP_SUB:  s[STB_SUB] = 1'b1;
      OP_LSH:  s[STB_LSH] = 1'b1;
      OP_RSH:  s[STB_RSH] = 1'b1;
      OP_AND:  s[STB_AND] = 1'b1;
      OP_OR:   s[STB_OR]  = 1'b1;
      OP_XOR:  s[STB_XOR] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 4x4 register file, two combinational reads, one synchronous write
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_W-1:0]  ra1,
  input  logic [REG_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving the 4-bit ALU control interface
// Optional sticky overflow flag enabled by defining ALU_SEQ_STICKY_OVF_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LATENCY   = 1,
  parameter int SHIFT_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_ovf,
  output logic [REG_W-1:0]   res_rd,
  output logic               alu_add,
  output logic               alu_sub,
  output logic               alu_lsh,
  output logic               alu_rsh,
  output logic               alu_and,
  output logic               alu_or,
  output logic               alu_xor,
  output logic               alu_shift_load,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_overflow,
  input  logic               ovf_clear,
  output logic               ovf_sticky
);

  state_t            state, state_next;
  op_t               op_q;
  logic [REG_W-1:0]  rd_q;
  logic [CNT_W-1:0]  cnt;
  logic              first_q, ready_en;
  logic              accept, done;
  logic [NSTB-1:0]   strobe;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, wr_data;
  logic [REG_W-1:0]  wr_addr;
  logic              wr_en;

  op_t               in_op;
  logic [REG_W-1:0]  in_rd, in_rs, in_rt;
  logic [DATA_W-1:0] in_imm;

  assign in_op  = op_t'(instr[OP_LSB +: OP_W]);
  assign in_rd  = instr[RD_LSB +: REG_W];
  assign in_rs  = instr[RS_LSB +: REG_W];
  assign in_rt  = instr[RT_LSB +: REG_W];
  assign in_imm = instr[IMM_LSB +: DATA_W];

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ready_en keeps instr_ready low on the cycle reset is released
  always_comb begin
    state_next     = state;
    instr_ready    = 1'b0;
    res_valid      = 1'b0;
    strobe         = '0;
    alu_shift_load = 1'b0;
    accept         = 1'b0;
    done           = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = ready_en;
        if (ready_en && instr_valid) begin
          accept     = 1'b1;
          state_next = (in_op == OP_LDI) ? ST_WB : ST_EXEC;
        end
      end
      ST_EXEC: begin
        strobe         = strobe_of(op_q);
        alu_shift_load = first_q && is_shift(op_q);
        if (cnt == '0) begin
          done       = 1'b1;
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign alu_add = strobe[STB_ADD];
  assign alu_sub = strobe[STB_SUB];
  assign alu_lsh = strobe[STB_LSH];
  assign alu_rsh = strobe[STB_RSH];
  assign alu_and = strobe[STB_AND];
  assign alu_or  = strobe[STB_OR];
  assign alu_xor = strobe[STB_XOR];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_en <= 1'b0;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      cnt      <= '0;
      first_q  <= 1'b0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      res_data <= '0;
      res_ovf  <= 1'b0;
      res_rd   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        op_q    <= in_op;
        rd_q    <= in_rd;
        first_q <= 1'b1;
        cnt     <= is_shift(in_op) ? CNT_W'(SHIFT_LATENCY) : CNT_W'(ALU_LATENCY);
        if (in_op == OP_LDI) begin
          res_data <= in_imm;
          res_ovf  <= 1'b0;
          res_rd   <= in_rd;
        end else begin
          alu_in1 <= rf_rd1;
          alu_in2 <= rf_rd2;
        end
      end
      if (state == ST_EXEC) begin
        first_q <= 1'b0;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (done) begin
        res_data <= alu_out;
        res_ovf  <= alu_overflow;
        res_rd   <= rd_q;
      end
    end
  end

  // Write-back happens on the same edge that captures the result
  assign wr_en   = done || (accept && (in_op == OP_LDI));
  assign wr_addr = done ? rd_q : in_rd;
  assign wr_data = done ? alu_out : in_imm;

  alu_seq_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .wa    (wr_addr),
    .wd    (wr_data),
    .ra1   (in_rs),
    .ra2   (in_rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic sticky;
  always_ff @(posedge clk) begin
    if (!reset)                    sticky <= 1'b0;
    else if (done && alu_overflow) sticky <= 1'b1;
    else if (ovf_clear)            sticky <= 1'b0;
  end
  assign ovf_sticky = sticky;
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = ovf_clear;
  assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [10:0] instr;
  logic        res_valid, res_ready;
  logic [3:0]  res_data;
  logic        res_ovf;
  logic [1:0]  res_rd;
  logic        alu_add, alu_sub, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor;
  logic        alu_shift_load;
  logic [3:0]  alu_in1, alu_in2, alu_out;
  logic        alu_overflow;
  logic        ovf_clear, ovf_sticky;

  int vectors = 0;
  int miscompares = 0;

`ifdef ALU_SEQ_STICKY_OVF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic [6:0] stb;
  assign stb = {alu_xor, alu_or, alu_and, alu_rsh, alu_lsh, alu_sub, alu_add};

  alu_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_ovf        (res_ovf),
    .res_rd         (res_rd),
    .alu_add        (alu_add),
    .alu_sub        (alu_sub),
    .alu_lsh        (alu_lsh),
    .alu_rsh        (alu_rsh),
    .alu_and        (alu_and),
    .alu_or         (alu_or),
    .alu_xor        (alu_xor),
    .alu_shift_load (alu_shift_load),
    .alu_in1        (alu_in1),
    .alu_in2        (alu_in2),
    .alu_out        (alu_out),
    .alu_overflow   (alu_overflow),
    .ovf_clear      (ovf_clear),
    .ovf_sticky     (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: registered result, zero when no strobe is active
  always @(posedge clk) begin
    if (alu_add)      {alu_overflow, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
    else if (alu_sub) {alu_overflow, alu_out} <= {1'b0, alu_in1} - {1'b0, alu_in2};
    else if (alu_lsh) {alu_overflow, alu_out} <= {alu_in1[3], alu_in1[2:0], 1'b0};
    else if (alu_rsh) {alu_overflow, alu_out} <= {alu_in1[0], 1'b0, alu_in1[3:1]};
    else if (alu_and) {alu_overflow, alu_out} <= {1'b0, alu_in1 & alu_in2};
    else if (alu_or)  {alu_overflow, alu_out} <= {1'b0, alu_in1 | alu_in2};
    else if (alu_xor) {alu_overflow, alu_out} <= {1'b0, alu_in1 ^ alu_in2};
    else              {alu_overflow, alu_out} <= 5'd0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers an instruction and returns in cycle 1 (just after the accept edge)
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [3:0] imm);
    int n = 0;
    instr       = {op, rd, rs, imm};
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout instr_ready never rose");
    end
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout res_valid never rose");
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_valid = 1'b1; instr = {3'd7, 2'd1, 2'd0, 4'd5};
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({instr_ready, res_valid, res_data, res_ovf, res_rd, stb, alu_shift_load,
           alu_in1, alu_in2, ovf_sticky} !== 28'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d got ready=%b valid=%b data=%h stb=%b want all 0",
                 i, instr_ready, res_valid, res_data, stb);
      end
    end
    reset = 1'b1; instr_valid = 1'b0;
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_ready got %b want 0", instr_ready);
    end
    tick();
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_after_ready got %b want 1", instr_ready);
    end
  endtask

  task automatic test_add();
    issue(3'd7, 2'd1, 2'd0, 4'd9); drain();
    issue(3'd7, 2'd2, 2'd0, 4'd8); drain();
    issue(3'd0, 2'd3, 2'd1, 4'b0010);
    vectors++;
    if (stb !== 7'b0000001 || alu_in1 !== 4'd9 || alu_in2 !== 4'd8 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_c1 got stb=%b in1=%h in2=%h valid=%b want 0000001 9 8 0",
               stb, alu_in1, alu_in2, res_valid);
    end
    tick();
    vectors++;
    if (stb !== 7'b0000001 || res_valid !== 1'b0) begin
      miscompares++; $display("FAIL add_c2 got stb=%b valid=%b want 0000001 0", stb, res_valid);
    end
    tick();
    vectors++;
    if (res_valid !== 1'b1 || stb !== 7'd0 || instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL add_c3_ctrl got valid=%b stb=%b ready=%b want 1 0 0", res_valid, stb, instr_ready);
    end
    vectors++;
    if (res_data !== 4'h1 || res_ovf !== 1'b1 || res_rd !== 2'd3) begin
      miscompares++;
      $display("FAIL add_c3_result got data=%h ovf=%b rd=%0d want 1 1 3", res_data, res_ovf, res_rd);
    end
    vectors++;
    if (ovf_sticky !== STICKY) begin
      miscompares++; $display("FAIL add_sticky got %b want %b", ovf_sticky, STICKY);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    vectors++;
    if (instr_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 4'h1) begin
      miscompares++;
      $display("FAIL add_after_hs got ready=%b valid=%b data=%h want 1 0 1", instr_ready, res_valid, res_data);
    end
  endtask

  task automatic test_sticky();
    issue(3'd4, 2'd0, 2'd1, 4'b0010);
    tick(); tick();
    vectors++;
    if (res_data !== 4'h8 || res_ovf !== 1'b0 || ovf_sticky !== STICKY) begin
      miscompares++;
      $display("FAIL and_result got data=%h ovf=%b sticky=%b want 8 0 %b", res_data, res_ovf, ovf_sticky, STICKY);
    end
    drain();
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    vectors++;
    if (ovf_sticky !== 1'b0) begin
      miscompares++; $display("FAIL sticky_clear got %b want 0", ovf_sticky);
    end
  endtask

  task automatic test_sub_stall_xor();
    issue(3'd7, 2'd0, 2'd0, 4'd3); drain();
    issue(3'd7, 2'd1, 2'd0, 4'd5); drain();
    issue(3'd1, 2'd2, 2'd0, 4'b0001);
    tick(); tick();
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 4'hE || res_ovf !== 1'b1 || res_rd !== 2'd2) begin
      miscompares++;
      $display("FAIL sub_result got valid=%b data=%h ovf=%b rd=%0d want 1 e 1 2",
               res_valid, res_data, res_ovf, res_rd);
    end
    instr_valid = 1'b1; instr = {3'd7, 2'd3, 2'd0, 4'd15};
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (res_valid !== 1'b1 || res_data !== 4'hE || res_rd !== 2'd2 || instr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_cycle %0d got valid=%b data=%h rd=%0d ready=%b want 1 e 2 0",
                 i, res_valid, res_data, res_rd, instr_ready);
      end
    end
    instr_valid = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    issue(3'd6, 2'd3, 2'd0, 4'b0001);
    tick(); tick();
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 4'h6 || res_ovf !== 1'b0 || res_rd !== 2'd3) begin
      miscompares++;
      $display("FAIL xor_result got valid=%b data=%h ovf=%b rd=%0d want 1 6 0 3",
               res_valid, res_data, res_ovf, res_rd);
    end
    drain();
  endtask

  task automatic test_lsh();
    issue(3'd7, 2'd0, 2'd0, 4'hB); drain();
    issue(3'd2, 2'd1, 2'd0, 4'd0);
    vectors++;
    if (alu_shift_load !== 1'b1 || stb !== 7'b0000100) begin
      miscompares++; $display("FAIL lsh_c1 got load=%b stb=%b want 1 0000100", alu_shift_load, stb);
    end
    tick();
    vectors++;
    if (alu_shift_load !== 1'b0 || stb !== 7'b0000100) begin
      miscompares++; $display("FAIL lsh_c2 got load=%b stb=%b want 0 0000100", alu_shift_load, stb);
    end
    tick();
    vectors++;
    if (stb !== 7'b0000100 || res_valid !== 1'b0) begin
      miscompares++; $display("FAIL lsh_c3 got stb=%b valid=%b want 0000100 0", stb, res_valid);
    end
    tick();
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 4'h6 || res_ovf !== 1'b1 || res_rd !== 2'd1 || stb !== 7'd0) begin
      miscompares++;
      $display("FAIL lsh_c4 got valid=%b data=%h ovf=%b rd=%0d stb=%b want 1 6 1 1 0",
               res_valid, res_data, res_ovf, res_rd, stb);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    issue(3'd7, 2'd0, 2'd0, 4'd3); drain();
    issue(3'd0, 2'd1, 2'd0, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (stb !== 7'd0 || res_valid !== 1'b0 || instr_ready !== 1'b0 || res_data !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset got stb=%b valid=%b ready=%b data=%h want 0 0 0 0",
               stb, res_valid, instr_ready, res_data);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (res_valid !== 1'b0 || stb !== 7'd0) begin
      miscompares++; $display("FAIL midreset_noresult got valid=%b stb=%b want 0 0", res_valid, stb);
    end
    issue(3'd0, 2'd2, 2'd0, 4'd1);
    vectors++;
    if (alu_in1 !== 4'd0 || alu_in2 !== 4'd0) begin
      miscompares++; $display("FAIL midreset_regfile got in1=%h in2=%h want 0 0", alu_in1, alu_in2);
    end
    drain();
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr = '0; res_ready = 1'b0; ovf_clear = 1'b0;
    test_reset();
    test_add();
    test_sticky();
    test_sub_stall_xor();
    test_lsh();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
